// File: rtl/online_digit_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : online_digit_serializer_pkg
//  Purpose  : Shared defaults, width helpers, FSM state type and the
//             illegal-digit pattern for the online digit serializer.
//  Revision : 1.0  initial release
// ============================================================================
package online_digit_serializer_pkg;

  localparam int NO_OF_DIGITS_DEF = 8;
  localparam int RADIX_BITS_DEF   = 3;

  // Width of one packed word of signed digits
  function automatic int num_bits_f(input int n, input int rb);
    return n * rb;
  endfunction

  // Width of the exact signed value of an n-digit word (|v| <= R^n - 1)
  function automatic int val_w_f(input int n, input int rb);
    return n * (rb - 1) + 1;
  endfunction

  // The only pattern outside the symmetric set: 1 followed by zeros (-R)
  function automatic logic [31:0] illegal_digit_f(input int rb);
    return 32'd1 << (rb - 1);
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/online_digit_accum.sv
`default_nettype none
// ============================================================================
//  Module   : online_digit_accum
//  Purpose  : MSD-first value accumulator (acc*R + digit) with sticky
//             illegal-digit detection.
//  Revision : 1.0  initial release
// ============================================================================
module online_digit_accum
  import online_digit_serializer_pkg::*;
#(
  parameter int no_of_digits = NO_OF_DIGITS_DEF,
  parameter int radix_bits   = RADIX_BITS_DEF,
  localparam int VAL_W       = val_w_f(no_of_digits, radix_bits)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    xfer_i,
  input  logic [radix_bits-1:0]   dig_i,
  output logic signed [VAL_W-1:0] acc_next_o,
  output logic                    err_o
);

  localparam logic [31:0] ILL_PAT = illegal_digit_f(radix_bits);

  logic signed [VAL_W-1:0] acc_q, acc_d;
  logic signed [VAL_W-1:0] w_dig_ext;
  logic                    w_illegal;
  logic                    err_q, err_d;

  // Next value: shift by log2(R) then add the sign-extended digit
  always_comb begin
    w_dig_ext  = VAL_W'(signed'(dig_i));
    acc_next_o = (acc_q <<< (radix_bits - 1)) + w_dig_ext;
    w_illegal  = (dig_i == ILL_PAT[radix_bits-1:0]);
    acc_d      = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (xfer_i) begin
      acc_d = acc_next_o;
    end
    err_d = err_q | (xfer_i & w_illegal);
  end

  // Accumulator and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/online_digit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : online_digit_serializer
//  Purpose  : Captures a word of signed redundant digits and streams it
//             MSD-first with a valid/ready handshake, tracking its exact value.
//  Revision : 1.0  initial release
// ============================================================================
module online_digit_serializer
  import online_digit_serializer_pkg::*;
#(
  parameter int no_of_digits = NO_OF_DIGITS_DEF,
  parameter int radix_bits   = RADIX_BITS_DEF,
  localparam int NUM_BITS    = num_bits_f(no_of_digits, radix_bits),
  localparam int VAL_W       = val_w_f(no_of_digits, radix_bits)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_BITS-1:0]     in_word,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [radix_bits-1:0]   dig_out,
  output logic                    dig_valid,
  input  logic                    dig_ready,
  output logic                    dig_first,
  output logic                    dig_last,
  output logic signed [VAL_W-1:0] ref_value,
  output logic                    ref_valid,
  output logic                    dig_err
);

  localparam int CNT_W = (no_of_digits > 1) ? $clog2(no_of_digits) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(no_of_digits - 1);

  state_e                  state_q, state_d;
  logic [NUM_BITS-1:0]     sreg_q, sreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rdy_q, rdy_d;
  logic signed [VAL_W-1:0] ref_value_q, ref_value_d;
  logic                    ref_valid_q, ref_valid_d;

  logic                    w_stream;
  logic                    w_cap;
  logic                    w_xfer;
  logic                    w_last;
  logic signed [VAL_W-1:0] w_acc_next;

  assign w_stream = (state_q == ST_STREAM);
  assign w_cap    = (state_q == ST_IDLE) && in_valid && rdy_q;
  assign w_xfer   = w_stream && dig_ready;
  assign w_last   = w_stream && (cnt_q == CNT_LAST);

  // Next-state: capture in IDLE, shift/count per transfer, return after LSD
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    ref_value_d = ref_value_q;
    ref_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_cap) begin
          sreg_d  = in_word;
          cnt_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (dig_ready) begin
          sreg_d = sreg_q << radix_bits;
          cnt_d  = cnt_q + CNT_W'(1);
          if (w_last) begin
            cnt_d       = '0;
            state_d     = ST_IDLE;
            ref_value_d = w_acc_next;
            ref_valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Ready is a registered copy of "next state is IDLE" so it stays low in reset
    rdy_d = (state_d == ST_IDLE);
  end

  // State, shift register, counter and reference outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      rdy_q       <= 1'b0;
      ref_value_q <= '0;
      ref_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      rdy_q       <= rdy_d;
      ref_value_q <= ref_value_d;
      ref_valid_q <= ref_valid_d;
    end
  end

  online_digit_accum #(
    .no_of_digits (no_of_digits),
    .radix_bits   (radix_bits)
  ) u_accum (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (w_cap),
    .xfer_i     (w_xfer),
    .dig_i      (dig_out),
    .acc_next_o (w_acc_next),
    .err_o      (dig_err)
  );

  assign in_ready  = rdy_q;
  assign dig_out   = sreg_q[NUM_BITS-1 -: radix_bits];
  assign dig_valid = w_stream;
  assign dig_first = w_stream && (cnt_q == '0);
  assign dig_last  = w_last;
  assign ref_value = ref_value_q;
  assign ref_valid = ref_valid_q;

endmodule
`default_nettype wire

// File: doc/online_digit_serializer.md
Name: online_digit_serializer

Overview:
- Downstream consumer of the parallel random-digit generator. Captures one `NUM_BITS`-wide word of signed redundant digits and streams it MSD-first, one digit per accepted transfer, into an online-arithmetic operator under test.
- Tracks the exact two's-complement value of the streamed number so the bench can check the operator result.
- Flags any digit outside the symmetric digit set. The generator masks that digit, so a flag indicates an upstream fault.

Parameters:
- `no_of_digits`, 8: digits per word.
- `radix_bits`, 3: bits per signed digit. Radix `R = 2^(radix_bits-1)`. Legal digit set is -(R-1)..(R-1).
- `NUM_BITS` (localparam), `no_of_digits*radix_bits`: input word width.
- `VAL_W` (localparam), `no_of_digits*(radix_bits-1)+1`: signed reference value width.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_word`  in  `NUM_BITS`  digit word. Digit k occupies bits `[k*radix_bits +: radix_bits]`. Digit `no_of_digits-1` is the MSD.
- `in_valid`  in  1  `in_word` valid. May be tied 1 when the generator free-runs.
- `in_ready`  out  1  block can capture a word.
- `dig_out`  out  `radix_bits`  current digit, two's complement.
- `dig_valid`  out  1  `dig_out` valid.
- `dig_ready`  in  1  consumer accepts the digit.
- `dig_first`  out  1  `dig_out` is the MSD of the word.
- `dig_last`  out  1  `dig_out` is the LSD of the word.
- `ref_value`  out  `VAL_W`  signed value of the last completed word.
- `ref_valid`  out  1  one-cycle pulse when `ref_value` updates.
- `dig_err`  out  1  sticky illegal-digit flag.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE;
  - shift register, counter and accumulator to 0;
  - `in_ready`=0 during reset;
  - `dig_valid`, `dig_first`, `dig_last`, `ref_valid`, `dig_err` = 0;
  - `ref_value`=0;
  - `dig_out`=0.
- State IDLE:
  - `in_ready`=1, `dig_valid`=0.
  - Capture happens when `in_valid` && `in_ready` at edge t. The word loads into the shift register, counter=0, accumulator=0, and the state moves to STREAM.
- State STREAM:
  - `dig_valid`=1, `in_ready`=0.
  - `dig_out` = top `radix_bits` of the shift register. The first digit is therefore valid from cycle t+1.
  - `dig_first` = (counter==0). `dig_last` = (counter==`no_of_digits`-1).
- Transfer:
  - A transfer occurs on `dig_valid` && `dig_ready`.
  - On a transfer: accumulator <= accumulator*R + sign_extend(`dig_out`); shift register <= shift register << `radix_bits` (zero fill); counter++.
  - `dig_ready`=0 holds `dig_out`, `dig_first`, `dig_last` and `dig_valid` stable. There are no bubbles, and there is no limit on the stall length.
- Last transfer (`dig_last`):
  - Next cycle: `ref_value` = final accumulator value, `ref_valid`=1 for exactly one cycle, state=IDLE.
  - `in_ready` is registered from state. Minimum period per word is `no_of_digits`+1 cycles.
- Width and arithmetic:
  - The accumulator is `VAL_W` signed. Multiply by R is a left shift by `radix_bits-1`.
  - Bound |value| ≤ R^n − 1, so no overflow is possible for legal digits.
- Illegal digit:
  - An illegal digit is pattern 1 followed by zeros (value −R).
  - On a transfer of an illegal digit, `dig_err` <= 1 and stays set until reset. The digit is still streamed and accumulated unchanged.
- Boundary conditions:
  - `in_valid` while in STREAM: ignored, no capture, word not consumed.
  - `no_of_digits`=1: the single digit has both `dig_first` and `dig_last` = 1.
  - Reset mid-stream: the word in flight is discarded, no `ref_valid` is produced, and all outputs take their reset values immediately.
  - After reset deassertion, `in_ready` rises on the first clock edge.

Decomposition:
- Shared package holds:
  - `radix_bits` and `no_of_digits` defaults;
  - derived `NUM_BITS` and `VAL_W` functions;
  - an illegal-digit constant function returning {1'b1, {radix_bits-1{1'b0}}}.
- One sub-module is natural: `online_digit_accum`. It contains the accumulator, sign extension, multiply-by-R and the illegal-digit check, and is driven by a transfer strobe plus the digit.
- FSM, shift register and counter stay in the top level.

Test Plan (`radix_bits`=3, `no_of_digits`=4, R=4, `VAL_W`=9):
- Reset then word 12'b001_011_111_101, `in_valid`=1, `dig_ready`=1:
  - digits 1,3,−1,−3 stream on cycles t+1..t+4, `dig_first` at t+1, `dig_last` at t+4;
  - `ref_value`=105 with `ref_valid` pulse at t+5;
  - `dig_err`=0.
- All-digits word 011_011_011_011 → `ref_value`=255. All-digits word 101_101_101_101 → `ref_value`=−255 (9'h101).
- Same word as the first scenario with `dig_ready` low for 3 cycles on the second digit:
  - `dig_out`=011 is held throughout the stall;
  - `ref_value`=105 one cycle after the delayed last transfer.
- Word 100_000_000_001:
  - `dig_err` rises after the first transfer and stays 1 through following words;
  - `ref_value`=−255 (−4·64+1).
- Reset asserted asynchronously during the second digit: `dig_valid`=0 and `in_ready`=0 immediately. After release, the next word streams correctly and no stale `ref_valid` pulse appears.
- `in_valid` held 1 continuously with changing words:
  - exactly one word is captured per 5 cycles;
  - words presented during STREAM are not captured.
